// File: rtl/sm4_axis_core.sv
// Multi-cycle Zksed scalar SM4 core (sm4ed / sm4ks) fed by four AXI-Stream operand channels.
// Optional macro SM4_BACK2BACK_EN: also accept the next request while in DONE.
module sm4_axis_core #(
  parameter int unsigned EXTRA_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_a_tvalid,
  output logic        s_axis_a_tready,
  input  logic [31:0] s_axis_a_tdata,
  input  logic        s_axis_b_tvalid,
  output logic        s_axis_b_tready,
  input  logic [31:0] s_axis_b_tdata,
  input  logic        s_axis_bs_tvalid,
  output logic        s_axis_bs_tready,
  input  logic [1:0]  s_axis_bs_tdata,
  input  logic        s_axis_operation_tvalid,
  output logic        s_axis_operation_tready,
  input  logic        s_axis_operation_tdata,
  output logic        m_axis_result_tvalid,
  output logic [31:0] m_axis_result_tdata
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {S_IDLE, S_SBOX, S_WAIT, S_LIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                ready_q, ready_nxt, valid_nxt;
  logic                accept_c;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rs1_q, rs2_q;
  logic [1:0]          bs_q;
  logic                op_q;
  logic [BYTE_W-1:0]   x_q, sbox_in, sbox_out;
  logic [DATA_W-1:0]   x32, y_ed, y_ks, y, y_rot, rd;

  // Standard SM4 S-box as a case ROM
  function automatic logic [7:0] sbox(input logic [7:0] a);
    sbox = 8'h00;
    case (a)
      8'h00: sbox = 8'hD6; 8'h01: sbox = 8'h90; 8'h02: sbox = 8'hE9; 8'h03: sbox = 8'hFE; 8'h04: sbox = 8'hCC; 8'h05: sbox = 8'hE1; 8'h06: sbox = 8'h3D; 8'h07: sbox = 8'hB7;
      8'h08: sbox = 8'h16; 8'h09: sbox = 8'hB6; 8'h0A: sbox = 8'h14; 8'h0B: sbox = 8'hC2; 8'h0C: sbox = 8'h28; 8'h0D: sbox = 8'hFB; 8'h0E: sbox = 8'h2C; 8'h0F: sbox = 8'h05;
      8'h10: sbox = 8'h2B; 8'h11: sbox = 8'h67; 8'h12: sbox = 8'h9A; 8'h13: sbox = 8'h76; 8'h14: sbox = 8'h2A; 8'h15: sbox = 8'hBE; 8'h16: sbox = 8'h04; 8'h17: sbox = 8'hC3;
      8'h18: sbox = 8'hAA; 8'h19: sbox = 8'h44; 8'h1A: sbox = 8'h13; 8'h1B: sbox = 8'h26; 8'h1C: sbox = 8'h49; 8'h1D: sbox = 8'h86; 8'h1E: sbox = 8'h06; 8'h1F: sbox = 8'h99;
      8'h20: sbox = 8'h9C; 8'h21: sbox = 8'h42; 8'h22: sbox = 8'h50; 8'h23: sbox = 8'hF4; 8'h24: sbox = 8'h91; 8'h25: sbox = 8'hEF; 8'h26: sbox = 8'h98; 8'h27: sbox = 8'h7A;
      8'h28: sbox = 8'h33; 8'h29: sbox = 8'h54; 8'h2A: sbox = 8'h0B; 8'h2B: sbox = 8'h43; 8'h2C: sbox = 8'hED; 8'h2D: sbox = 8'hCF; 8'h2E: sbox = 8'hAC; 8'h2F: sbox = 8'h62;
      8'h30: sbox = 8'hE4; 8'h31: sbox = 8'hB3; 8'h32: sbox = 8'h1C; 8'h33: sbox = 8'hA9; 8'h34: sbox = 8'hC9; 8'h35: sbox = 8'h08; 8'h36: sbox = 8'hE8; 8'h37: sbox = 8'h95;
      8'h38: sbox = 8'h80; 8'h39: sbox = 8'hDF; 8'h3A: sbox = 8'h94; 8'h3B: sbox = 8'hFA; 8'h3C: sbox = 8'h75; 8'h3D: sbox = 8'h8F; 8'h3E: sbox = 8'h3F; 8'h3F: sbox = 8'hA6;
      8'h40: sbox = 8'h47; 8'h41: sbox = 8'h07; 8'h42: sbox = 8'hA7; 8'h43: sbox = 8'hFC; 8'h44: sbox = 8'hF3; 8'h45: sbox = 8'h73; 8'h46: sbox = 8'h17; 8'h47: sbox = 8'hBA;
      8'h48: sbox = 8'h83; 8'h49: sbox = 8'h59; 8'h4A: sbox = 8'h3C; 8'h4B: sbox = 8'h19; 8'h4C: sbox = 8'hE6; 8'h4D: sbox = 8'h85; 8'h4E: sbox = 8'h4F; 8'h4F: sbox = 8'hA8;
      8'h50: sbox = 8'h68; 8'h51: sbox = 8'h6B; 8'h52: sbox = 8'h81; 8'h53: sbox = 8'hB2; 8'h54: sbox = 8'h71; 8'h55: sbox = 8'h64; 8'h56: sbox = 8'hDA; 8'h57: sbox = 8'h8B;
      8'h58: sbox = 8'hF8; 8'h59: sbox = 8'hEB; 8'h5A: sbox = 8'h0F; 8'h5B: sbox = 8'h4B; 8'h5C: sbox = 8'h70; 8'h5D: sbox = 8'h56; 8'h5E: sbox = 8'h9D; 8'h5F: sbox = 8'h35;
      8'h60: sbox = 8'h1E; 8'h61: sbox = 8'h24; 8'h62: sbox = 8'h0E; 8'h63: sbox = 8'h5E; 8'h64: sbox = 8'h63; 8'h65: sbox = 8'h58; 8'h66: sbox = 8'hD1; 8'h67: sbox = 8'hA2;
      8'h68: sbox = 8'h25; 8'h69: sbox = 8'h22; 8'h6A: sbox = 8'h7C; 8'h6B: sbox = 8'h3B; 8'h6C: sbox = 8'h01; 8'h6D: sbox = 8'h21; 8'h6E: sbox = 8'h78; 8'h6F: sbox = 8'h87;
      8'h70: sbox = 8'hD4; 8'h71: sbox = 8'h00; 8'h72: sbox = 8'h46; 8'h73: sbox = 8'h57; 8'h74: sbox = 8'h9F; 8'h75: sbox = 8'hD3; 8'h76: sbox = 8'h27; 8'h77: sbox = 8'h52;
      8'h78: sbox = 8'h4C; 8'h79: sbox = 8'h36; 8'h7A: sbox = 8'h02; 8'h7B: sbox = 8'hE7; 8'h7C: sbox = 8'hA0; 8'h7D: sbox = 8'hC4; 8'h7E: sbox = 8'hC8; 8'h7F: sbox = 8'h9E;
      8'h80: sbox = 8'hEA; 8'h81: sbox = 8'hBF; 8'h82: sbox = 8'h8A; 8'h83: sbox = 8'hD2; 8'h84: sbox = 8'h40; 8'h85: sbox = 8'hC7; 8'h86: sbox = 8'h38; 8'h87: sbox = 8'hB5;
      8'h88: sbox = 8'hA3; 8'h89: sbox = 8'hF7; 8'h8A: sbox = 8'hF2; 8'h8B: sbox = 8'hCE; 8'h8C: sbox = 8'hF9; 8'h8D: sbox = 8'h61; 8'h8E: sbox = 8'h15; 8'h8F: sbox = 8'hA1;
      8'h90: sbox = 8'hE0; 8'h91: sbox = 8'hAE; 8'h92: sbox = 8'h5D; 8'h93: sbox = 8'hA4; 8'h94: sbox = 8'h9B; 8'h95: sbox = 8'h34; 8'h96: sbox = 8'h1A; 8'h97: sbox = 8'h55;
      8'h98: sbox = 8'hAD; 8'h99: sbox = 8'h93; 8'h9A: sbox = 8'h32; 8'h9B: sbox = 8'h30; 8'h9C: sbox = 8'hF5; 8'h9D: sbox = 8'h8C; 8'h9E: sbox = 8'hB1; 8'h9F: sbox = 8'hE3;
      8'hA0: sbox = 8'h1D; 8'hA1: sbox = 8'hF6; 8'hA2: sbox = 8'hE2; 8'hA3: sbox = 8'h2E; 8'hA4: sbox = 8'h82; 8'hA5: sbox = 8'h66; 8'hA6: sbox = 8'hCA; 8'hA7: sbox = 8'h60;
      8'hA8: sbox = 8'hC0; 8'hA9: sbox = 8'h29; 8'hAA: sbox = 8'h23; 8'hAB: sbox = 8'hAB; 8'hAC: sbox = 8'h0D; 8'hAD: sbox = 8'h53; 8'hAE: sbox = 8'h4E; 8'hAF: sbox = 8'h6F;
      8'hB0: sbox = 8'hD5; 8'hB1: sbox = 8'hDB; 8'hB2: sbox = 8'h37; 8'hB3: sbox = 8'h45; 8'hB4: sbox = 8'hDE; 8'hB5: sbox = 8'hFD; 8'hB6: sbox = 8'h8E; 8'hB7: sbox = 8'h2F;
      8'hB8: sbox = 8'h03; 8'hB9: sbox = 8'hFF; 8'hBA: sbox = 8'h6A; 8'hBB: sbox = 8'h72; 8'hBC: sbox = 8'h6D; 8'hBD: sbox = 8'h6C; 8'hBE: sbox = 8'h5B; 8'hBF: sbox = 8'h51;
      8'hC0: sbox = 8'h8D; 8'hC1: sbox = 8'h1B; 8'hC2: sbox = 8'hAF; 8'hC3: sbox = 8'h92; 8'hC4: sbox = 8'hBB; 8'hC5: sbox = 8'hDD; 8'hC6: sbox = 8'hBC; 8'hC7: sbox = 8'h7F;
      8'hC8: sbox = 8'h11; 8'hC9: sbox = 8'hD9; 8'hCA: sbox = 8'h5C; 8'hCB: sbox = 8'h41; 8'hCC: sbox = 8'h1F; 8'hCD: sbox = 8'h10; 8'hCE: sbox = 8'h5A; 8'hCF: sbox = 8'hD8;
      8'hD0: sbox = 8'h0A; 8'hD1: sbox = 8'hC1; 8'hD2: sbox = 8'h31; 8'hD3: sbox = 8'h88; 8'hD4: sbox = 8'hA5; 8'hD5: sbox = 8'hCD; 8'hD6: sbox = 8'h7B; 8'hD7: sbox = 8'hBD;
      8'hD8: sbox = 8'h2D; 8'hD9: sbox = 8'h74; 8'hDA: sbox = 8'hD0; 8'hDB: sbox = 8'h12; 8'hDC: sbox = 8'hB8; 8'hDD: sbox = 8'hE5; 8'hDE: sbox = 8'hB4; 8'hDF: sbox = 8'hB0;
      8'hE0: sbox = 8'h89; 8'hE1: sbox = 8'h69; 8'hE2: sbox = 8'h97; 8'hE3: sbox = 8'h4A; 8'hE4: sbox = 8'h0C; 8'hE5: sbox = 8'h96; 8'hE6: sbox = 8'h77; 8'hE7: sbox = 8'h7E;
      8'hE8: sbox = 8'h65; 8'hE9: sbox = 8'hB9; 8'hEA: sbox = 8'hF1; 8'hEB: sbox = 8'h09; 8'hEC: sbox = 8'hC5; 8'hED: sbox = 8'h6E; 8'hEE: sbox = 8'hC6; 8'hEF: sbox = 8'h84;
      8'hF0: sbox = 8'h18; 8'hF1: sbox = 8'hF0; 8'hF2: sbox = 8'h7D; 8'hF3: sbox = 8'hEC; 8'hF4: sbox = 8'h3A; 8'hF5: sbox = 8'hDC; 8'hF6: sbox = 8'h4D; 8'hF7: sbox = 8'h20;
      8'hF8: sbox = 8'h79; 8'hF9: sbox = 8'hEE; 8'hFA: sbox = 8'h5F; 8'hFB: sbox = 8'h3E; 8'hFC: sbox = 8'hD7; 8'hFD: sbox = 8'hCB; 8'hFE: sbox = 8'h39; 8'hFF: sbox = 8'h48;
      default: sbox = 8'h00;
    endcase
  endfunction

  assign accept_c = ready_q & s_axis_a_tvalid & s_axis_b_tvalid & s_axis_bs_tvalid & s_axis_operation_tvalid;

  assign s_axis_a_tready         = ready_q;
  assign s_axis_b_tready         = ready_q;
  assign s_axis_bs_tready        = ready_q;
  assign s_axis_operation_tready = ready_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; in DONE accept_c can only be set when back-to-back issue is enabled
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept_c) state_nxt = S_SBOX;
      S_SBOX:  state_nxt = (EXTRA_LAT == 0) ? S_LIN : S_WAIT;
      S_WAIT:  if (cnt == CNT_W'(EXTRA_LAT - 1)) state_nxt = S_LIN;
      S_LIN:   state_nxt = S_DONE;
      S_DONE:  state_nxt = accept_c ? S_SBOX : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode, evaluated against the upcoming state so outputs come straight from flops
  always_comb begin
    ready_nxt = 1'b0;
    valid_nxt = 1'b0;
`ifdef SM4_BACK2BACK_EN
    ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
`else
    ready_nxt = (state_nxt == S_IDLE);
`endif
    valid_nxt = (state == S_LIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q              <= 1'b1;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      cnt                  <= '0;
    end else begin
      ready_q              <= ready_nxt;
      m_axis_result_tvalid <= valid_nxt;
      if (state == S_LIN) m_axis_result_tdata <= rd;
      if (state == S_WAIT) cnt <= cnt + CNT_W'(1);
      else                 cnt <= '0;
    end
  end

  // Operand latch and S-box stage
  always_ff @(posedge clk) begin
    if (accept_c) begin
      rs1_q <= s_axis_a_tdata;
      rs2_q <= s_axis_b_tdata;
      bs_q  <= s_axis_bs_tdata;
      op_q  <= s_axis_operation_tdata;
    end
    if (state == S_SBOX) x_q <= sbox_out;
  end

  assign sbox_in  = rs2_q[{bs_q, 3'b000} +: BYTE_W];
  assign sbox_out = sbox(sbox_in);

  // Linear layer, rotate back into the selected byte lane, XOR into rs1
  assign x32  = {24'h000000, x_q};
  assign y_ed = x32 ^ (x32 << 8) ^ (x32 << 2) ^ (x32 << 18)
              ^ ((x32 & 32'h0000003F) << 26) ^ ((x32 & 32'h000000C0) << 10);
  assign y_ks = x32 ^ ((x32 & 32'h00000007) << 29) ^ ((x32 & 32'h000000FE) << 7)
              ^ ((x32 & 32'h00000001) << 23) ^ ((x32 & 32'h000000F8) << 13);
  assign y    = op_q ? y_ks : y_ed;

  always_comb begin
    y_rot = y;
    case (bs_q)
      2'd0:    y_rot = y;
      2'd1:    y_rot = {y[23:0], y[31:24]};
      2'd2:    y_rot = {y[15:0], y[31:16]};
      default: y_rot = {y[7:0],  y[31:8]};
    endcase
  end

  assign rd = y_rot ^ rs1_q;

endmodule

// File: tb/tb_sm4_axis_core.sv
// Scoreboard bench for sm4_axis_core: accepted requests push a reference result, a monitor pops and compares.
// Honours SM4_BACK2BACK_EN for the expected issue interval and tready pattern.
module tb_sm4_axis_core;
  localparam int unsigned LAT = 3;
`ifdef SM4_BACK2BACK_EN
  localparam int unsigned ISSUE = 3 + LAT;
`else
  localparam int unsigned ISSUE = 4 + LAT;
`endif

  localparam logic [7:0] SBOX_T [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_v = 1'b0, b_v = 1'b0, bs_v = 1'b0, op_v = 1'b0;
  logic        a_r, b_r, bs_r, op_r;
  logic [31:0] a_d = '0, b_d = '0;
  logic [1:0]  bs_d = '0;
  logic        op_d = 1'b0;
  logic        res_v;
  logic [31:0] res_d;

  int unsigned checks = 0, failures = 0;
  int unsigned cyc = 0, ready_at = 0, last_acc = 0, n_acc = 0;
  logic [31:0] held = '0;
  exp_t        exp_q[$];

  sm4_axis_core #(.EXTRA_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .s_axis_a_tvalid(a_v), .s_axis_a_tready(a_r), .s_axis_a_tdata(a_d),
    .s_axis_b_tvalid(b_v), .s_axis_b_tready(b_r), .s_axis_b_tdata(b_d),
    .s_axis_bs_tvalid(bs_v), .s_axis_bs_tready(bs_r), .s_axis_bs_tdata(bs_d),
    .s_axis_operation_tvalid(op_v), .s_axis_operation_tready(op_r), .s_axis_operation_tdata(op_d),
    .m_axis_result_tvalid(res_v), .m_axis_result_tdata(res_d)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: S-box lookup, SM4 linear mix, rotate left by 8*bs, XOR rs1
  function automatic logic [31:0] ref_rd(input logic [31:0] rs1, input logic [31:0] rs2,
                                         input logic [1:0] bs, input logic op);
    int unsigned sh;
    logic [31:0] x, y;
    sh = 32'(bs) * 8;
    x  = 32'(SBOX_T[8'(rs2 >> sh)]);
    if (!op) y = x ^ (x << 8) ^ (x << 2) ^ (x << 18) ^ ((x & 32'h3F) << 26) ^ ((x & 32'hC0) << 10);
    else     y = x ^ ((x & 32'h07) << 29) ^ ((x & 32'hFE) << 7) ^ ((x & 32'h01) << 23) ^ ((x & 32'hF8) << 13);
    if (sh != 0) y = (y << sh) | (y >> (32 - sh));
    return y ^ rs1;
  endfunction

  // Monitor: readiness timing, result scoreboard, held data, and acceptance capture
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held     = '0;
      ready_at = 0;
    end else begin
      chk("tready", 32'({a_r, b_r, bs_r, op_r}), (cyc >= ready_at) ? 32'hF : 32'h0);
      if (res_v) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_tvalid: got tvalid=1 data=0x%08h, expected no result (cycle %0d)", res_d, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("result_data", res_d, e.rd);
          chk("latency", cyc - e.acc, 32'(2 + LAT));
          held = e.rd;
        end
      end else begin
        chk("held_data", res_d, held);
      end
      if (a_v && b_v && bs_v && op_v && a_r && b_r && bs_r && op_r) begin
        e.rd  = ref_rd(a_d, b_d, bs_d, op_d);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        last_acc = cyc + 1;
        ready_at = cyc + ISSUE;
        n_acc++;
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                      input logic op, input int unsigned skew);
    int unsigned d [4];
    int unsigned n;
    for (int i = 0; i < 4; i++) d[i] = (skew == 0) ? 0 : $urandom_range(skew, 0);
    d[$urandom_range(3, 0)] = skew;
    a_d = a; b_d = b; bs_d = s; op_d = op;
    for (int unsigned t = 0; t <= skew; t++) begin
      a_v = (d[0] <= t); b_v = (d[1] <= t); bs_v = (d[2] <= t); op_v = (d[3] <= t);
      if (t != skew) begin @(posedge clk); #1; end
    end
    n = 0;
    @(negedge clk);
    while (!a_r && n < 100) begin @(negedge clk); n++; end
    if (!a_r) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got tready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk); #1;
    a_v = 1'b0; b_v = 1'b0; bs_v = 1'b0; op_v = 1'b0;
    a_d = $urandom; b_d = $urandom; bs_d = 2'($urandom); op_d = 1'($urandom);
  endtask

  task automatic wait_res(output logic [31:0] d);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!res_v && n < 100) begin @(negedge clk); n++; end
    if (!res_v) begin
      checks++;
      failures++;
      $display("FAIL result_timeout: got no tvalid in %0d cycles, expected a result", n);
      d = '0;
    end else d = res_d;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
    end
  endtask

  initial begin
    logic [31:0] r;
    int unsigned n0, acc1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_tvalid", 32'(res_v), 32'h0);
    chk("reset_tdata", res_d, 32'h0);
    chk("reset_tready", 32'({a_r, b_r, bs_r, op_r}), 32'hF);
    @(posedge clk); #1;
    rst = 1'b0;

    // Known-answer vectors
    send(32'h0, 32'h0, 2'd0, 1'b0, 0);
    wait_res(r);
    chk("kat_sm4ed_zero", r, 32'h5B5BD58E);
    send(32'h0, 32'h0, 2'd0, 1'b1, 0);
    wait_res(r);
    chk("kat_sm4ks_zero", r, 32'hC01A6BD6);
    send(32'hFFFFFFFF, 32'h0, 2'd1, 1'b0, 0);
    wait_res(r);
    chk("kat_sm4ed_rot8", r, 32'hA42A71A4);

    // Operation channel withheld: nothing consumed, then accepted once it rises
    @(posedge clk); #1;
    n0 = n_acc;
    a_d = 32'h12345678; b_d = 32'h9ABCDEF0; bs_d = 2'd2; op_d = 1'b1;
    a_v = 1'b1; b_v = 1'b1; bs_v = 1'b1; op_v = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("partial_no_tvalid", 32'(res_v), 32'h0);
    end
    @(posedge clk); #1;
    chk("partial_no_accept", n_acc, n0);
    op_v = 1'b1;
    @(posedge clk); #1;
    chk("partial_accept", n_acc, n0 + 1);
    chk("busy_tready", 32'(a_r), 32'h0);
    a_v = 1'b0; b_v = 1'b0; bs_v = 1'b0; op_v = 1'b0;

    // Second request held valid while busy
    send($urandom, $urandom, 2'($urandom), 1'b0, 0);
    acc1 = last_acc;
    send($urandom, $urandom, 2'($urandom), 1'b1, 0);
    chk("issue_interval", last_acc - acc1, ISSUE);
    drain();

    // Reset one cycle after acceptance aborts the request silently
    send($urandom, $urandom, 2'($urandom), 1'($urandom), 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_tready", 32'({a_r, b_r, bs_r, op_r}), 32'hF);
    chk("post_reset_tdata", res_d, 32'h0);
    repeat (12) @(negedge clk);

    // Randomized traffic with staggered valids and random gaps
    for (int i = 0; i < 60; i++) begin
      logic [31:0] b;
      case ($urandom_range(5, 0))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      send($urandom, b, 2'($urandom), 1'($urandom), $urandom_range(3, 0));
      repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
    end
    drain();
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule
